// File: rtl/ysyx_23060025_wb.sv
// Writeback stage: commits LSU payloads to the GPR and CSR write ports, sequences ecall and halts on ebreak.
// Optional retire/memory performance counters are enabled by defining YSYX_23060025_WB_PERF_CNT_EN.
module ysyx_23060025_wb #(
    parameter int unsigned                DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]      ECALL_CAUSE = DATA_WIDTH'(11)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid_i,
    input  logic                  wb_reg_wen_i,
    input  logic [4:0]            wb_wreg_i,
    input  logic [DATA_WIDTH-1:0] wb_reg_wdata_i,
    input  logic [DATA_WIDTH-1:0] wb_csr_wdata_i,
    input  logic [2:0]            wb_csr_type_i,
    input  logic                  wb_memory_inst_i,
    input  logic                  wb_ebreak_flag_i,
    output logic                  wb_ready_o,
    output logic                  rf_wen_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  csr_wen_o,
    output logic [1:0]            csr_sel_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  commit_o,
`ifdef YSYX_23060025_WB_PERF_CNT_EN
    output logic [63:0]           perf_retire_o,
    output logic [63:0]           perf_mem_o,
`endif
    output logic                  halt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ECALL2 = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam logic [2:0] TYPE_ECALL = 3'd5;

    state_t state;
    state_t next_state;

    logic is_ecall;
    assign is_ecall = !wb_ebreak_flag_i && (wb_csr_type_i == TYPE_ECALL);

    // Outputs are gated by reset so every port reads 0 while reset is held.
    always_comb begin
        next_state  = state;
        wb_ready_o  = 1'b0;
        rf_wen_o    = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        csr_wen_o   = 1'b0;
        csr_sel_o   = '0;
        csr_wdata_o = '0;
        commit_o    = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    wb_ready_o = !(wb_valid_i && (wb_ebreak_flag_i || is_ecall));
                    if (wb_valid_i) begin
                        if (is_ecall) begin
                            csr_wen_o   = 1'b1;
                            csr_sel_o   = 2'd2;
                            csr_wdata_o = wb_csr_wdata_i;
                            next_state  = ECALL2;
                        end else begin
                            rf_wen_o   = wb_reg_wen_i && (wb_wreg_i != 5'd0);
                            rf_waddr_o = wb_wreg_i;
                            rf_wdata_o = wb_reg_wdata_i;
                            commit_o   = 1'b1;
                            if (wb_ebreak_flag_i) begin
                                next_state = HALT;
                            end else if (wb_csr_type_i >= 3'd1 && wb_csr_type_i <= 3'd4) begin
                                csr_wen_o   = 1'b1;
                                csr_sel_o   = 2'(wb_csr_type_i - 3'd1);
                                csr_wdata_o = wb_csr_wdata_i;
                            end
                        end
                    end
                end
                ECALL2: begin
                    wb_ready_o  = 1'b1;
                    csr_wen_o   = 1'b1;
                    csr_sel_o   = 2'd3;
                    csr_wdata_o = ECALL_CAUSE;
                    commit_o    = 1'b1;
                    next_state  = IDLE;
                end
                HALT: begin
                    next_state = HALT;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            halt_o <= 1'b0;
        end else begin
            state  <= next_state;
            halt_o <= (next_state == HALT);
        end
    end

`ifdef YSYX_23060025_WB_PERF_CNT_EN
    // The ecall retires on its second cycle, when the payload may already be stale,
    // so its memory flag is captured at accept time.
    logic ecall_mem;
    logic commit_mem;

    assign commit_mem = commit_o && ((state == ECALL2) ? ecall_mem : wb_memory_inst_i);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ecall_mem     <= 1'b0;
            perf_retire_o <= '0;
            perf_mem_o    <= '0;
        end else begin
            if (state == IDLE && wb_valid_i && is_ecall) begin
                ecall_mem <= wb_memory_inst_i;
            end
            if (commit_o) begin
                perf_retire_o <= perf_retire_o + 64'd1;
            end
            if (commit_mem) begin
                perf_mem_o <= perf_mem_o + 64'd1;
            end
        end
    end
`else
    logic unused_mem_flag;
    assign unused_mem_flag = wb_memory_inst_i;
`endif

endmodule

// File: tb/tb_ysyx_23060025_wb.sv
// Directed bench for the writeback stage: table of single-cycle commits plus hand-written ecall/ebreak/reset sequences.
module tb_ysyx_23060025_wb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic        wb_reg_wen_i = 1'b0;
    logic [4:0]  wb_wreg_i = '0;
    logic [31:0] wb_reg_wdata_i = '0;
    logic [31:0] wb_csr_wdata_i = '0;
    logic [2:0]  wb_csr_type_i = '0;
    logic        wb_memory_inst_i = 1'b0;
    logic        wb_ebreak_flag_i = 1'b0;
    logic        wb_ready_o;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        csr_wen_o;
    logic [1:0]  csr_sel_o;
    logic [31:0] csr_wdata_o;
    logic        commit_o;
    logic        halt_o;
`ifdef YSYX_23060025_WB_PERF_CNT_EN
    logic [63:0] perf_retire_o;
    logic [63:0] perf_mem_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ysyx_23060025_wb #(.DATA_WIDTH(32), .ECALL_CAUSE(32'd11)) dut (
        .clock            (clock),
        .reset            (reset),
        .wb_valid_i       (wb_valid_i),
        .wb_reg_wen_i     (wb_reg_wen_i),
        .wb_wreg_i        (wb_wreg_i),
        .wb_reg_wdata_i   (wb_reg_wdata_i),
        .wb_csr_wdata_i   (wb_csr_wdata_i),
        .wb_csr_type_i    (wb_csr_type_i),
        .wb_memory_inst_i (wb_memory_inst_i),
        .wb_ebreak_flag_i (wb_ebreak_flag_i),
        .wb_ready_o       (wb_ready_o),
        .rf_wen_o         (rf_wen_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .csr_wen_o        (csr_wen_o),
        .csr_sel_o        (csr_sel_o),
        .csr_wdata_o      (csr_wdata_o),
        .commit_o         (commit_o),
`ifdef YSYX_23060025_WB_PERF_CNT_EN
        .perf_retire_o    (perf_retire_o),
        .perf_mem_o       (perf_mem_o),
`endif
        .halt_o           (halt_o)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        reg_wen;
        logic [4:0]  wreg;
        logic [31:0] reg_wdata;
        logic [31:0] csr_wdata;
        logic [2:0]  csr_type;
        logic        mem;
        logic        e_rf_wen;
        logic        e_csr_wen;
        logic [1:0]  e_csr_sel;
        logic        e_commit;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] wr, input logic [31:0] rd,
                         input logic [31:0] cd, input logic [2:0] ty, input logic mem, input logic eb);
        wb_valid_i       = v;
        wb_reg_wen_i     = rw;
        wb_wreg_i        = wr;
        wb_reg_wdata_i   = rd;
        wb_csr_wdata_i   = cd;
        wb_csr_type_i    = ty;
        wb_memory_inst_i = mem;
        wb_ebreak_flag_i = eb;
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk({tag, ".rf_wen"}, 64'(rf_wen_o), 64'd0);
        chk({tag, ".csr_wen"}, 64'(csr_wen_o), 64'd0);
        chk({tag, ".commit"}, 64'(commit_o), 64'd0);
    endtask

    task automatic add(input string n, input logic v, input logic rw, input logic [4:0] wr,
                       input logic [31:0] rd, input logic [31:0] cd, input logic [2:0] ty, input logic mem,
                       input logic erf, input logic ecsr, input logic [1:0] esel, input logic ecm, input logic erdy);
        vec_t t;
        t.name = n; t.valid = v; t.reg_wen = rw; t.wreg = wr; t.reg_wdata = rd; t.csr_wdata = cd;
        t.csr_type = ty; t.mem = mem; t.e_rf_wen = erf; t.e_csr_wen = ecsr; t.e_csr_sel = esel;
        t.e_commit = ecm; t.e_ready = erdy;
        vecs.push_back(t);
    endtask

    initial begin
        //  name        v  rw wr  reg_wdata      csr_wdata      ty  mem  rf csr sel cm rdy
        add("gpr_x5",   1, 1, 5,  32'h0000_1234, 32'h0,         0, 0,   1, 0,  0,  1, 1);
        add("gpr_x0",   1, 1, 0,  32'hdead_beef, 32'h0,         0, 0,   0, 0,  0,  1, 1);
        add("mtvec_x3", 1, 1, 3,  32'h0000_aaaa, 32'h8000_0100, 2, 1,   1, 1,  1,  1, 1);
        add("mstatus",  1, 0, 7,  32'h0000_0001, 32'h0000_1800, 1, 0,   0, 1,  0,  1, 1);
        add("mepc",     1, 1, 31, 32'hffff_ffff, 32'h8000_0004, 3, 0,   1, 1,  2,  1, 1);
        add("mcause",   1, 1, 1,  32'h0000_0042, 32'h0000_0007, 4, 0,   1, 1,  3,  1, 1);
        add("mret",     1, 0, 2,  32'h0,         32'h1234_5678, 6, 0,   0, 0,  0,  1, 1);
        add("reserved", 1, 1, 4,  32'h0000_0099, 32'h1111_2222, 7, 0,   1, 0,  0,  1, 1);
        add("idle",     0, 1, 6,  32'h0000_0055, 32'h3333_4444, 2, 0,   0, 0,  0,  0, 1);

        // Outputs held at zero while reset is asserted, even with a valid payload.
        drive(1, 1, 5, 32'h1234, 32'h0, 0, 0, 0);
        #2;
        chk("rst.ready", 64'(wb_ready_o), 64'd0);
        chk("rst.commit", 64'(commit_o), 64'd0);
        chk("rst.rf_wen", 64'(rf_wen_o), 64'd0);
        chk("rst.halt", 64'(halt_o), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst.ready", 64'(wb_ready_o), 64'd1);
        chk_idle_quiet("post_rst");

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].valid, vecs[i].reg_wen, vecs[i].wreg, vecs[i].reg_wdata,
                  vecs[i].csr_wdata, vecs[i].csr_type, vecs[i].mem, 0);
            #1;
            chk({vecs[i].name, ".rf_wen"}, 64'(rf_wen_o), 64'(vecs[i].e_rf_wen));
            if (vecs[i].e_rf_wen) begin
                chk({vecs[i].name, ".rf_waddr"}, 64'(rf_waddr_o), 64'(vecs[i].wreg));
                chk({vecs[i].name, ".rf_wdata"}, 64'(rf_wdata_o), 64'(vecs[i].reg_wdata));
            end
            chk({vecs[i].name, ".csr_wen"}, 64'(csr_wen_o), 64'(vecs[i].e_csr_wen));
            if (vecs[i].e_csr_wen) begin
                chk({vecs[i].name, ".csr_sel"}, 64'(csr_sel_o), 64'(vecs[i].e_csr_sel));
                chk({vecs[i].name, ".csr_wdata"}, 64'(csr_wdata_o), 64'(vecs[i].csr_wdata));
            end
            chk({vecs[i].name, ".commit"}, 64'(commit_o), 64'(vecs[i].e_commit));
            chk({vecs[i].name, ".ready"}, 64'(wb_ready_o), 64'(vecs[i].e_ready));
        end

        // Ecall: mepc then mcause, stale payload ignored in the second cycle.
        @(negedge clock);
        drive(1, 1, 9, 32'h77, 32'h8000_0010, 5, 0, 0);
        #1;
        chk("ecall1.csr_wen", 64'(csr_wen_o), 64'd1);
        chk("ecall1.csr_sel", 64'(csr_sel_o), 64'd2);
        chk("ecall1.csr_wdata", 64'(csr_wdata_o), 64'h8000_0010);
        chk("ecall1.rf_wen", 64'(rf_wen_o), 64'd0);
        chk("ecall1.commit", 64'(commit_o), 64'd0);
        chk("ecall1.ready", 64'(wb_ready_o), 64'd0);
        @(negedge clock);
        drive(1, 1, 7, 32'h66, 32'hcafe_0000, 2, 1, 0);
        #1;
        chk("ecall2.csr_wen", 64'(csr_wen_o), 64'd1);
        chk("ecall2.csr_sel", 64'(csr_sel_o), 64'd3);
        chk("ecall2.csr_wdata", 64'(csr_wdata_o), 64'd11);
        chk("ecall2.rf_wen", 64'(rf_wen_o), 64'd0);
        chk("ecall2.commit", 64'(commit_o), 64'd1);
        chk("ecall2.ready", 64'(wb_ready_o), 64'd1);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_idle_quiet("after_ecall");
        chk("after_ecall.ready", 64'(wb_ready_o), 64'd1);

        // Reset during ECALL2 abandons the mcause write.
        @(negedge clock);
        drive(1, 0, 0, 0, 32'h8000_0020, 5, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_ecall.csr_sel", 64'(csr_sel_o), 64'd3);
        reset = 1'b0;
        #1;
        chk("mid_ecall_rst.csr_wen", 64'(csr_wen_o), 64'd0);
        chk("mid_ecall_rst.commit", 64'(commit_o), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk_idle_quiet("mid_ecall_after");
        chk("mid_ecall_after.ready", 64'(wb_ready_o), 64'd1);

        // Ebreak wins over csr_type, then the stage stays halted.
        @(negedge clock);
        drive(1, 1, 9, 32'h55, 32'h8000_0030, 5, 0, 1);
        #1;
        chk("ebreak.rf_wen", 64'(rf_wen_o), 64'd1);
        chk("ebreak.rf_waddr", 64'(rf_waddr_o), 64'd9);
        chk("ebreak.csr_wen", 64'(csr_wen_o), 64'd0);
        chk("ebreak.commit", 64'(commit_o), 64'd1);
        chk("ebreak.ready", 64'(wb_ready_o), 64'd0);
        chk("ebreak.halt_before", 64'(halt_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1, 1, 4, 32'h99, 32'h1, 2, 0, 0);
            #1;
            chk("halt.halt", 64'(halt_o), 64'd1);
            chk_idle_quiet("halt");
            chk("halt.ready", 64'(wb_ready_o), 64'd0);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("halt_rst.halt", 64'(halt_o), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        drive(1, 1, 12, 32'h42, 32'h0, 0, 0, 0);
        #1;
        chk("revive.commit", 64'(commit_o), 64'd1);
        chk("revive.ready", 64'(wb_ready_o), 64'd1);

`ifdef YSYX_23060025_WB_PERF_CNT_EN
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("perf.rst_retire", perf_retire_o, 64'd0);
        chk("perf.rst_mem", perf_mem_o, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 1, 1, 32'h1, 32'h0, 0, 0, 0);
        @(negedge clock);
        drive(1, 1, 2, 32'h2, 32'h0, 0, 1, 0);
        @(negedge clock);
        drive(1, 0, 0, 32'h0, 32'h5, 1, 0, 0);
        @(negedge clock);
        drive(1, 0, 0, 32'h0, 32'h8000_0040, 5, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("perf.mid_ecall_retire", perf_retire_o, 64'd3);
        @(negedge clock);
        #1;
        chk("perf.retire", perf_retire_o, 64'd4);
        chk("perf.mem", perf_mem_o, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_wb.md
Name: ysyx_23060025_wb

Overview:
- Writeback stage that consumes the registered LSU→WB payload.
- Accepts each valid instruction and commits it to the GPR write port and the CSR write port.
- Sequences the two-cycle ecall CSR update and halts the core on ebreak.
- Drives the ready handshake back toward the LSU; the LSU→WB register samples its payload on valid & ready.

Parameters:
- DATA_WIDTH, 32, width of GPR/CSR write data.
- ECALL_CAUSE, 32'd11, value written to mcause on ecall.

Ports:
- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_valid_i  input  1  payload valid from LSU→WB register.
- wb_reg_wen_i  input  1  GPR write request.
- wb_wreg_i  input  5  GPR destination index.
- wb_reg_wdata_i  input  DATA_WIDTH  GPR write data.
- wb_csr_wdata_i  input  DATA_WIDTH  CSR write data (the pc for ecall).
- wb_csr_type_i  input  3  0 none, 1 mstatus, 2 mtvec, 3 mepc, 4 mcause, 5 ecall, 6 mret, 7 reserved (= none).
- wb_memory_inst_i  input  1  instruction was a load/store.
- wb_ebreak_flag_i  input  1  instruction is ebreak.
- wb_ready_o  output  1  to LSU; stage can take a new payload at the next edge.
- rf_wen_o  output  1  GPR write enable.
- rf_waddr_o  output  5  GPR write index.
- rf_wdata_o  output  DATA_WIDTH  GPR write data.
- csr_wen_o  output  1  CSR write enable.
- csr_sel_o  output  2  CSR target: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause.
- csr_wdata_o  output  DATA_WIDTH  CSR write data.
- commit_o  output  1  one-cycle retire pulse.
- halt_o  output  1  sticky ebreak halt.

Behaviour:
- Reset: reset=0 asynchronously forces state IDLE and halt_o=0. Every output is 0 during reset, except wb_ready_o, which is 1 after reset deasserts.
- States:
  - IDLE: normal.
  - ECALL2: second ecall cycle.
  - HALT: terminal.
- Accept: only when state==IDLE && wb_valid_i. A payload presented in ECALL2 or HALT is stale and is ignored with no writes.
- Accept of a normal instruction (type 0–4, 6, 7; not ebreak):
  - rf_wen_o = wb_reg_wen_i && wb_wreg_i!=0; rf_waddr_o / rf_wdata_o pass through.
  - Type 1–4: csr_wen_o=1, csr_sel_o=type-1, csr_wdata_o=wb_csr_wdata_i. Type 6 and 7: no CSR write.
  - commit_o=1 in the same cycle (combinational, zero latency). Stay IDLE.
- Accept of ecall (type 5):
  - Cycle 1: csr_wen_o=1, csr_sel_o=2, csr_wdata_o=wb_csr_wdata_i. rf_wen_o=0, commit_o=0. Next state ECALL2.
  - Cycle 2 (ECALL2): csr_wen_o=1, csr_sel_o=3, csr_wdata_o=ECALL_CAUSE, commit_o=1. Next state IDLE.
- Accept of ebreak (ebreak flag wins over csr_type):
  - GPR write as for a normal instruction; commit_o=1; no CSR write.
  - Next state HALT. halt_o=1 from the next cycle, sticky until reset.
- wb_ready_o:
  - 1 in ECALL2.
  - 1 in IDLE unless (wb_valid_i && (type==5 || ebreak)).
  - 0 in HALT.
  - Combinational from state and inputs.
- In HALT: no writes, commit_o=0, inputs ignored.
- Reset mid-ecall (in ECALL2): mcause write is abandoned; state returns to IDLE.
- Idle cycles (wb_valid_i=0): every write enable and commit_o is 0.

Optional Feature:
- Macro: YSYX_23060025_WB_PERF_CNT_EN.
- Enabled:
  - Adds outputs perf_retire_o[63:0], incremented on every commit_o.
  - Adds perf_mem_o[63:0], incremented on every committed instruction with wb_memory_inst_i=1; an ecall counts on its ECALL2 cycle only.
  - Both counters reset to 0, wrap modulo 2^64, and freeze in HALT.
- Disabled: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then valid with reg_wen=1, wreg=5, wdata=0x1234 → same cycle rf_wen_o=1, waddr=5, wdata=0x1234, commit_o=1, wb_ready_o=1.
- Valid with reg_wen=1, wreg=0 → rf_wen_o=0, commit_o=1.
- Valid with type=5, csr_wdata=0x80000010 → cycle 1: csr_sel=2, data 0x80000010, ready=0. Cycle 2: csr_sel=3, data 11, commit_o=1, ready=1. A stale valid in cycle 2 causes no extra writes.
- Valid with type=2, csr_wdata=0x80000100, reg_wen=1, wreg=3 → same cycle: CSR write to mtvec and GPR x3, one commit pulse.
- Valid with ebreak=1 → commit_o=1, ready=0; halt_o=1 next cycle. Further valids produce no writes until reset=0, which clears halt_o asynchronously.
- PERF_CNT_EN on: 3 committed instructions (one with memory_inst=1) followed by an ecall → perf_retire_o=4, perf_mem_o=1.
